// File: rtl/frame_pkg.sv
// -----------------------------------------------------------------------------
// frame_pkg
// Shared definitions for the host/device framing blocks: start-of-frame
// markers, response status codes, CRC-8 polynomial, the response builder
// state enum, the captured-request payload struct and a length clamp helper.
// No ports (package).
// -----------------------------------------------------------------------------
package frame_pkg;

  localparam logic [7:0] SOF_HOST_TO_DEVICE = 8'hAA;
  localparam logic [7:0] SOF_DEVICE_TO_HOST = 8'h55;

  localparam logic [7:0] STATUS_OK        = 8'h00;
  localparam logic [7:0] STATUS_CRC_ERR   = 8'h01;
  localparam logic [7:0] STATUS_CMD_INV   = 8'h02;
  localparam logic [7:0] STATUS_LEN_RANGE = 8'h03;
  localparam logic [7:0] STATUS_TIMEOUT   = 8'h04;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_STATUS,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_CRC,
    ST_DONE
  } builder_state_t;

  // Response fields latched when a build request is accepted.
  typedef struct packed {
    logic [7:0]  status;
    logic [7:0]  cmd;
    logic        has_addr;
    logic [31:0] addr;
    logic [6:0]  len;
  } resp_req_t;

  // Limit a requested payload length to what the data buffer can supply.
  function automatic logic [6:0] clamp_len(input logic [6:0] len,
                                           input int unsigned max_len);
    if (32'(len) > max_len) return 7'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/crc8_update.sv
// -----------------------------------------------------------------------------
// crc8_update
// Combinational single-byte CRC-8 step (poly CRC8_POLY, MSB first, no
// reflection, no final XOR). Shared by the frame parser and builder.
// Ports:
//   crc_in   [7:0] in   running CRC before this byte
//   data_in  [7:0] in   byte being folded in
//   crc_out  [7:0] out  running CRC after this byte
// -----------------------------------------------------------------------------
module crc8_update
  import frame_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data_in;
    for (int i = 0; i < 8; i++) begin
      if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
      else      c = {c[6:0], 1'b0};
    end
    crc_out = c;
  end

endmodule

// File: rtl/frame_builder.sv
// -----------------------------------------------------------------------------
// frame_builder
// Serialises one device-to-host response frame into a TX FIFO:
//   SOF(0x55) STATUS CMD [ADDR0..ADDR3] [DATA x len] CRC8
// CRC covers STATUS through the last DATA byte.
// Optional feature macro: FRAME_BUILDER_TIMEOUT_EN -- aborts a frame after
// TIMEOUT_CYCLES consecutive FIFO-full cycles and pulses build_error.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   build_start         one-cycle request, accepted only when idle
//   resp_status/cmd     status and echoed command bytes
//   resp_has_addr/addr  optional 32-bit address, sent little-endian
//   resp_data_len       payload length (clamped to MAX_DATA_BYTES)
//   data_rd_addr/data   payload buffer read port (combinational read data)
//   tx_fifo_data/wr_en  FIFO write port, tx_fifo_full back-pressure
//   build_busy          frame in progress
//   build_done          pulse, frame fully written
//   build_error         pulse, frame aborted (timeout build only)
// -----------------------------------------------------------------------------
module frame_builder
  import frame_pkg::*;
#(
  parameter int unsigned MAX_DATA_BYTES = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        build_start,
  input  logic [7:0]  resp_status,
  input  logic [7:0]  resp_cmd,
  input  logic        resp_has_addr,
  input  logic [31:0] resp_addr,
  input  logic [6:0]  resp_data_len,
  output logic [5:0]  data_rd_addr,
  input  logic [7:0]  data_rd_data,
  output logic [7:0]  tx_fifo_data,
  output logic        tx_fifo_wr_en,
  input  logic        tx_fifo_full,
  output logic        build_busy,
  output logic        build_done,
  output logic        build_error
);

  builder_state_t state;
  resp_req_t      req;
  logic [6:0]     idx;
  logic [7:0]     crc;
  logic [7:0]     crc_next;
  logic [7:0]     cur_byte;
  logic           in_write;
  logic           wr;

  // Byte presented by the current state and whether that state emits one.
  always_comb begin
    cur_byte = 8'h00;
    in_write = 1'b0;
    case (state)
      ST_SOF:    begin cur_byte = SOF_DEVICE_TO_HOST; in_write = 1'b1; end
      ST_STATUS: begin cur_byte = req.status;         in_write = 1'b1; end
      ST_CMD:    begin cur_byte = req.cmd;            in_write = 1'b1; end
      ST_ADDR: begin
        in_write = 1'b1;
        case (idx[1:0])
          2'd0:    cur_byte = req.addr[7:0];
          2'd1:    cur_byte = req.addr[15:8];
          2'd2:    cur_byte = req.addr[23:16];
          default: cur_byte = req.addr[31:24];
        endcase
      end
      ST_DATA:   begin cur_byte = data_rd_data;       in_write = 1'b1; end
      ST_CRC:    begin cur_byte = crc;                in_write = 1'b1; end
      default:   ;
    endcase
  end

  // The write strobe must react to full in the same cycle, so the FIFO port
  // is decoded from registered state; reset masks it immediately.
  assign wr            = in_write && !tx_fifo_full && !rst;
  assign tx_fifo_wr_en = wr;
  assign tx_fifo_data  = wr ? cur_byte : 8'h00;
  assign data_rd_addr  = (state == ST_DATA && !rst) ? idx[5:0] : 6'd0;

  crc8_update u_crc (
    .crc_in  (crc),
    .data_in (cur_byte),
    .crc_out (crc_next)
  );

`ifdef FRAME_BUILDER_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_cnt;
  logic               error_q;
  assign build_error = error_q;
`else
  assign build_error = 1'b0;
`endif

  // Builder FSM; every transition out of a byte state waits for a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      req        <= '0;
      idx        <= 7'd0;
      crc        <= 8'h00;
      build_busy <= 1'b0;
      build_done <= 1'b0;
`ifdef FRAME_BUILDER_TIMEOUT_EN
      stall_cnt  <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      build_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (build_start) begin
            req.status   <= resp_status;
            req.cmd      <= resp_cmd;
            req.has_addr <= resp_has_addr;
            req.addr     <= resp_addr;
            req.len      <= clamp_len(resp_data_len, MAX_DATA_BYTES);
            idx          <= 7'd0;
            crc          <= 8'h00;
            build_busy   <= 1'b1;
            state        <= ST_SOF;
          end
        end
        ST_SOF: if (wr) state <= ST_STATUS;
        ST_STATUS: begin
          if (wr) begin
            crc   <= crc_next;
            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (wr) begin
            crc <= crc_next;
            idx <= 7'd0;
            if (req.has_addr)          state <= ST_ADDR;
            else if (req.len != 7'd0)  state <= ST_DATA;
            else                       state <= ST_CRC;
          end
        end
        ST_ADDR: begin
          if (wr) begin
            crc <= crc_next;
            if (idx == 7'd3) begin
              idx   <= 7'd0;
              state <= (req.len != 7'd0) ? ST_DATA : ST_CRC;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        ST_DATA: begin
          if (wr) begin
            crc <= crc_next;
            if (idx == req.len - 7'd1) begin
              idx   <= 7'd0;
              state <= ST_CRC;
            end else begin
              idx <= idx + 7'd1;
            end
          end
        end
        ST_CRC: begin
          if (wr) begin
            build_done <= 1'b1;
            build_busy <= 1'b0;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
`ifdef FRAME_BUILDER_TIMEOUT_EN
      // Consecutive back-pressure cycles; the abort overrides the FSM above.
      error_q <= 1'b0;
      if (in_write) begin
        if (wr) begin
          stall_cnt <= '0;
        end else if (stall_cnt == STALL_W'(TIMEOUT_CYCLES - 1)) begin
          stall_cnt  <= '0;
          error_q    <= 1'b1;
          build_busy <= 1'b0;
          idx        <= 7'd0;
          crc        <= 8'h00;
          state      <= ST_IDLE;
        end else begin
          stall_cnt <= stall_cnt + STALL_W'(1);
        end
      end else begin
        stall_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// -----------------------------------------------------------------------------
// tb_frame_builder
// Self-checking bench for frame_builder: a directed vector table, hand-written
// reset/timeout sequences and randomized frames compared against a queue-based
// frame model built from the frame format rules.
// -----------------------------------------------------------------------------
module tb_frame_builder;

  logic        clk = 1'b0;
  logic        rst;
  logic        build_start;
  logic [7:0]  resp_status;
  logic [7:0]  resp_cmd;
  logic        resp_has_addr;
  logic [31:0] resp_addr;
  logic [6:0]  resp_data_len;
  logic [5:0]  data_rd_addr;
  logic [7:0]  data_rd_data;
  logic [7:0]  tx_fifo_data;
  logic        tx_fifo_wr_en;
  logic        tx_fifo_full;
  logic        build_busy;
  logic        build_done;
  logic        build_error;

  always #5 clk = ~clk;

  frame_builder #(.MAX_DATA_BYTES(64), .TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .build_start   (build_start),
    .resp_status   (resp_status),
    .resp_cmd      (resp_cmd),
    .resp_has_addr (resp_has_addr),
    .resp_addr     (resp_addr),
    .resp_data_len (resp_data_len),
    .data_rd_addr  (data_rd_addr),
    .data_rd_data  (data_rd_data),
    .tx_fifo_data  (tx_fifo_data),
    .tx_fifo_wr_en (tx_fifo_wr_en),
    .tx_fifo_full  (tx_fifo_full),
    .build_busy    (build_busy),
    .build_done    (build_done),
    .build_error   (build_error)
  );

  logic [7:0] mem [64];
  assign data_rd_data = mem[data_rd_addr];

  logic [7:0] cap_q[$];
  int         cap_rd[$];
  logic [7:0] exp_q[$];
  int         viol;
  int         n_done;
  int         n_cmp = 0;
  int         n_bad = 0;

  // Monitor every FIFO write mid-cycle.
  always @(negedge clk) begin
    if (tx_fifo_wr_en) begin
      cap_q.push_back(tx_fifo_data);
      cap_rd.push_back(int'(data_rd_addr));
      if (tx_fifo_full) viol++;
    end
    if (build_done) n_done++;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference frame: assembled from the format rules, CRC by bitwise division.
  task automatic make_expected(input logic [7:0] st, input logic [7:0] cmd,
                               input bit ha, input logic [31:0] ad, input int ln);
    int n;
    logic [7:0] r;
    logic [31:0] a;
    bit fb;
    exp_q.delete();
    exp_q.push_back(8'h55);
    exp_q.push_back(st);
    exp_q.push_back(cmd);
    a = ad;
    if (ha) for (int i = 0; i < 4; i++) begin
      exp_q.push_back(a[7:0]);
      a = a >> 8;
    end
    n = (ln > 64) ? 64 : ln;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[i]);
    r = 8'h00;
    for (int k = 1; k < exp_q.size(); k++)
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ exp_q[k][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    exp_q.push_back(r);
  endtask

  typedef struct {
    logic [7:0]  st;
    logic [7:0]  cmd;
    bit          ha;
    logic [31:0] ad;
    int          ln;
    int          fpct;
    int          ffrom;
    int          ffor;
    bit          again;
    int          exp_nbytes;
    int          exp_cycles;
    int          exp_crc;
  } vec_t;

  task automatic run_frame(input vec_t v, input string tag);
    int c, dcyc, nd0, mis, rderr, hdr, n, nexp;
    bit got;
    make_expected(v.st, v.cmd, v.ha, v.ad, v.ln);
    cap_q.delete();
    cap_rd.delete();
    viol = 0;
    nd0  = n_done;
    @(posedge clk); #1;
    resp_status   = v.st;
    resp_cmd      = v.cmd;
    resp_has_addr = v.ha;
    resp_addr     = v.ad;
    resp_data_len = 7'(v.ln);
    build_start   = 1'b1;
    tx_fifo_full  = 1'b0;
    @(posedge clk); #1;
    build_start   = 1'b0;
    resp_status   = 8'($urandom);
    resp_cmd      = 8'($urandom);
    resp_has_addr = 1'($urandom);
    resp_addr     = $urandom;
    resp_data_len = 7'($urandom);
    c = 1; got = 1'b0; dcyc = -1;
    while (!got && c < 2000) begin
      tx_fifo_full = (v.ffor > 0 && c >= v.ffrom && c < v.ffrom + v.ffor) ||
                     (int'($urandom_range(0, 99)) < v.fpct);
      build_start  = v.again && (c == 3);
      @(negedge clk);
      if (c == 1) chk({tag, " busy_after_accept"}, longint'(build_busy), 1);
      if (build_done) begin
        got  = 1'b1;
        dcyc = c;
        chk({tag, " busy_at_done"}, longint'(build_busy), 0);
      end else begin
        @(posedge clk); #1;
        c++;
      end
    end
    build_start  = 1'b0;
    tx_fifo_full = 1'b0;
    if (!got) chk({tag, " done_timeout"}, 0, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, " busy_after_done"}, longint'(build_busy), 0);
    repeat (4) @(posedge clk);
    #1;
    nexp = (v.exp_nbytes >= 0) ? v.exp_nbytes : exp_q.size();
    chk({tag, " nbytes"}, cap_q.size(), nexp);
    mis = 0;
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
      if (cap_q[k] !== exp_q[k]) mis++;
    chk({tag, " byte_mismatches"}, mis, 0);
    hdr = v.ha ? 7 : 3;
    n = (v.ln > 64) ? 64 : v.ln;
    rderr = 0;
    for (int k = hdr; k < hdr + n && k < cap_rd.size(); k++)
      if (cap_rd[k] != k - hdr) rderr++;
    chk({tag, " rd_addr_errors"}, rderr, 0);
    chk({tag, " wr_while_full"}, viol, 0);
    chk({tag, " done_pulses"}, n_done - nd0, 1);
    if (v.exp_cycles >= 0) chk({tag, " done_cycle"}, dcyc, v.exp_cycles);
    if (v.exp_crc >= 0)
      chk({tag, " crc"}, (cap_q.size() > 0) ? longint'(cap_q[cap_q.size()-1]) : -1,
          v.exp_crc);
  endtask

  vec_t vt[8];

  initial begin
    int c, nb, nd0;
    bit seen;
    vec_t rv;

    for (int i = 0; i < 64; i++) mem[i] = 8'(i * 37 + 11);
    n_done = 0;
    viol = 0;
    rst = 1'b1;
    build_start = 1'b0;
    resp_status = 8'h00; resp_cmd = 8'h00; resp_has_addr = 1'b0;
    resp_addr = 32'h0; resp_data_len = 7'd0; tx_fifo_full = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst wr_en", longint'(tx_fifo_wr_en), 0);
    chk("rst busy", longint'(build_busy), 0);
    chk("rst done", longint'(build_done), 0);
    chk("rst error", longint'(build_error), 0);
    chk("rst tx_data", longint'(tx_fifo_data), 0);
    chk("rst rd_addr", longint'(data_rd_addr), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    //        st     cmd    ha  addr          len fpct from for again nb cyc crc
    vt[0] = '{8'h00, 8'h00, 0, 32'h0,         0,  0,   0,   0,  0,    4,  5, 8'h00};
    vt[1] = '{8'h01, 8'h00, 0, 32'h0,         0,  0,   0,   0,  0,    4,  5, 8'h15};
    vt[2] = '{8'h00, 8'h10, 1, 32'h12345678,  2,  0,   0,   0,  0,   10, 11, -1};
    vt[3] = '{8'h00, 8'h21, 0, 32'h0,         8,  0,   6,   3,  0,   12, 16, -1};
    vt[4] = '{8'h00, 8'h33, 0, 32'h0,       100,  0,   0,   0,  1,   68, 69, -1};
    vt[5] = '{8'h04, 8'hA5, 1, 32'hDEADBEEF, 64, 40,   0,   0,  0,   72, -1, -1};
    vt[6] = '{8'h03, 8'h44, 0, 32'h0,       127,  0,   0,   0,  0,   68, 69, -1};
    vt[7] = '{8'h02, 8'h7F, 0, 32'h0,         1,  0,   0,   0,  0,    5,  6, -1};
    for (int i = 0; i < 8; i++) run_frame(vt[i], $sformatf("vec%0d", i));

    // Reset in the middle of a frame: no further writes, no resume.
    @(posedge clk); #1;
    resp_status = 8'h00; resp_cmd = 8'h55; resp_has_addr = 1'b1;
    resp_addr = 32'hCAFEF00D; resp_data_len = 7'd20; build_start = 1'b1;
    @(posedge clk); #1;
    build_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    nb  = cap_q.size();
    nd0 = n_done;
    @(negedge clk);
    chk("midrst wr_en", longint'(tx_fifo_wr_en), 0);
    chk("midrst rd_addr", longint'(data_rd_addr), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("midrst no_more_writes", cap_q.size() - nb, 0);
    chk("midrst busy", longint'(build_busy), 0);
    chk("midrst no_done", n_done - nd0, 0);

`ifdef FRAME_BUILDER_TIMEOUT_EN
    // FIFO held full from SOF: abort after 16 stall cycles, no done.
    @(posedge clk); #1;
    resp_has_addr = 1'b0; resp_data_len = 7'd4; build_start = 1'b1;
    @(posedge clk); #1;
    build_start = 1'b0;
    tx_fifo_full = 1'b1;
    nb = cap_q.size(); nd0 = n_done;
    c = 1; seen = 1'b0;
    while (!seen && c < 60) begin
      @(negedge clk);
      if (build_error) seen = 1'b1;
      else begin @(posedge clk); #1; c++; end
    end
    chk("timeout error_seen", longint'(seen), 1);
    chk("timeout error_cycle", c, 17);
    chk("timeout busy", longint'(build_busy), 0);
    @(posedge clk); #1;
    tx_fifo_full = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("timeout no_writes", cap_q.size() - nb, 0);
    chk("timeout no_done", n_done - nd0, 0);
`endif

    // Randomized frames against the model.
    for (int i = 0; i < 25; i++) begin
      for (int j = 0; j < 64; j++) mem[j] = 8'($urandom);
      rv.st = 8'($urandom_range(0, 4));
      rv.cmd = 8'($urandom);
      rv.ha = 1'($urandom);
      rv.ad = $urandom;
      rv.ln = int'($urandom_range(0, 127));
      rv.fpct = int'($urandom_range(0, 50));
      rv.ffrom = 0; rv.ffor = 0;
      rv.again = 1'($urandom);
      rv.exp_nbytes = -1; rv.exp_cycles = -1; rv.exp_crc = -1;
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_builder.md
FRAME_BUILDER -- requirements
Module: frame_builder

Interface
REQ-001 Parameter MAX_DATA_BYTES, default 64, maximum response payload bytes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000, cycles of continuous tx_fifo_full tolerated before abort (used only under FRAME_BUILDER_TIMEOUT_EN).
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 build_start  input  1  single-cycle request to emit one response frame.
REQ-006 resp_status  input  8  status byte (0x00 OK, 0x01 CRC_ERR, 0x02 CMD_INV, 0x03 LEN_RANGE, 0x04 TIMEOUT).
REQ-007 resp_cmd  input  8  echoed command byte.
REQ-008 resp_has_addr  input  1  include 4 address bytes.
REQ-009 resp_addr  input  32  address, sent little-endian.
REQ-010 resp_data_len  input  7  payload byte count, 0..127.
REQ-011 data_rd_addr  output  6  payload byte index.
REQ-012 data_rd_data  input  8  payload byte at data_rd_addr, combinational, same cycle.
REQ-013 tx_fifo_data  output  8  byte to TX FIFO.
REQ-014 tx_fifo_wr_en  output  1  write strobe.
REQ-015 tx_fifo_full  input  1  TX FIFO full.
REQ-016 build_busy  output  1  frame in progress.
REQ-017 build_done  output  1  one-cycle pulse, frame fully written.
REQ-018 build_error  output  1  one-cycle pulse, frame aborted (timeout build only).

Function
REQ-019 Frame order SHALL be: SOF 0x55, STATUS, CMD, [ADDR0..ADDR3 if has_addr], [DATA x len], CRC.
REQ-020 CRC SHALL be CRC-8, poly 0x07, init 0x00, no reflection, no final XOR, over STATUS through last DATA byte; SOF excluded.
REQ-021 build_start SHALL be accepted only in IDLE; all resp_* inputs SHALL be captured on acceptance; build_start while busy SHALL be ignored.
REQ-022 resp_data_len > MAX_DATA_BYTES SHALL be clamped to MAX_DATA_BYTES.
REQ-023 States: IDLE, SOF, STATUS, CMD, ADDR, DATA, CRC, DONE; ADDR and DATA use an internal byte index.
REQ-024 build_busy SHALL assert the cycle after acceptance and deassert in the cycle build_done pulses.
REQ-025 tx_fifo_wr_en SHALL never assert while tx_fifo_full is high; while full, the state, index, and CRC SHALL hold.
REQ-026 With FIFO never full, SOF SHALL be written the cycle after acceptance, with one byte per cycle thereafter.
REQ-027 CRC register SHALL update only on cycles where a CRC-covered byte is written.
REQ-028 data_rd_addr SHALL equal the current DATA index in DATA state and 0 otherwise.
REQ-029 build_done SHALL pulse in DONE, the cycle after the CRC write; the next cycle SHALL be IDLE.
REQ-030 A frame with has_addr=0 and len=0 SHALL be exactly 4 bytes.

Reset
REQ-031 While rst is high: state IDLE; tx_fifo_wr_en, build_busy, build_done, build_error all 0; tx_fifo_data, data_rd_addr, CRC, and counters all 0.
REQ-032 rst asserted mid-frame SHALL abandon the frame with no further writes; the frame SHALL NOT be resumed after reset.

Configuration
REQ-033 With FRAME_BUILDER_TIMEOUT_EN defined, a stall counter SHALL count consecutive full cycles while busy and clear on each write.
REQ-034 Under FRAME_BUILDER_TIMEOUT_EN, reaching TIMEOUT_CYCLES SHALL pulse build_error, skip build_done, and return to IDLE.
REQ-035 Without the macro, no stall counter SHALL exist, build_error SHALL be tied 0, and the block SHALL stall indefinitely.

Structure
REQ-036 A shared package frame_pkg SHALL hold SOF_HOST_TO_DEVICE (0xAA), SOF_DEVICE_TO_HOST (0x55), the STATUS_* codes, CRC8_POLY, and the builder state enum.
REQ-037 A combinational sub-module crc8_update (crc_in, data_in -> crc_out) SHALL perform the CRC step, shared with the parser.

Verification
REQ-038 status=0x00, cmd=0x00, no addr, len=0 -> bytes 55 00 00 00, with build_done 5 cycles after start.
REQ-039 status=0x01, cmd=0x00, no addr, len=0 -> bytes 55 01 00 15.
REQ-040 has_addr, addr=0x12345678, len=2 -> ADDR bytes 78 56 34 12; data_rd_addr 0 then 1; 10 bytes total.
REQ-041 tx_fifo_full high for 3 cycles mid-DATA -> no wr_en while full, byte order intact, CRC unchanged.
REQ-042 len=100 -> exactly 64 DATA bytes; build_start pulsed while busy -> no second frame.
REQ-043 FRAME_BUILDER_TIMEOUT_EN, TIMEOUT_CYCLES=16, full held -> build_error at stall cycle 16, no build_done, IDLE next cycle.
